// File: rtl/osr_autopull_engine_if.sv
// Handshake and instruction bundle between the PIO sequencer/TX FIFO (master)
// and the output shift register engine (slave).
interface osr_autopull_engine_if #(
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DATA_W);

  logic              cfg_shiftdir;
  logic              cfg_autopull;
  logic [CW-1:0]     cfg_pull_thresh;

  logic              mov_en;
  logic [DATA_W-1:0] mov_data;

  logic              pull_req;
  logic              pull_block;
  logic              pull_ifempty;
  logic [DATA_W-1:0] x_data;

  logic              out_en;
  logic [CW-1:0]     out_count;

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_valid;
  logic              fifo_ready;

  logic              stall;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CW:0]       osr_count;

  modport master (
    output cfg_shiftdir, cfg_autopull, cfg_pull_thresh,
    output mov_en, mov_data,
    output pull_req, pull_block, pull_ifempty, x_data,
    output out_en, out_count,
    output fifo_data, fifo_valid,
    input  fifo_ready, stall, out_data, out_valid, osr_count
  );

  modport slave (
    input  cfg_shiftdir, cfg_autopull, cfg_pull_thresh,
    input  mov_en, mov_data,
    input  pull_req, pull_block, pull_ifempty, x_data,
    input  out_en, out_count,
    input  fifo_data, fifo_valid,
    output fifo_ready, stall, out_data, out_valid, osr_count
  );
endinterface

// File: rtl/osr_autopull_engine.sv
// PIO output shift register with FIFO autopull, blocking/non-blocking PULL,
// PULL IfEmpty, sequencer stall and registered OUT data.
module osr_autopull_engine #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  osr_autopull_engine_if.slave bus
);
  localparam int CW    = $clog2(DATA_W);
  localparam int CNT_W = CW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic [DATA_W-1:0] osr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  // Effective threshold and shift count: a zero field encodes a full word.
  logic [CNT_W-1:0] t_eff;
  logic [CNT_W-1:0] n_eff;
  logic             over_thresh;

  assign t_eff       = (bus.cfg_pull_thresh == '0) ? FULL_CNT : {1'b0, bus.cfg_pull_thresh};
  assign n_eff       = (bus.out_count == '0)       ? FULL_CNT : {1'b0, bus.out_count};
  assign over_thresh = (cnt >= t_eff);

  // Request decode, mov_en > pull_req > out_en.
  logic do_pull;
  logic do_out;
  logic pull_skip;
  logic pull_fifo;
  logic pull_stall;
  logic pull_x;
  logic refill_bg;
  logic out_stall;
  logic out_go;

  assign do_pull    = !bus.mov_en && bus.pull_req;
  assign do_out     = !bus.mov_en && !bus.pull_req && bus.out_en;
  assign pull_skip  = bus.pull_ifempty && !over_thresh;
  assign pull_fifo  = do_pull && !pull_skip && bus.fifo_valid;
  assign pull_stall = do_pull && !pull_skip && !bus.fifo_valid && bus.pull_block;
  assign pull_x     = do_pull && !pull_skip && !bus.fifo_valid && !bus.pull_block;
  assign refill_bg  = !bus.mov_en && !bus.pull_req && bus.cfg_autopull
                      && over_thresh && bus.fifo_valid;
  assign out_stall  = do_out && bus.cfg_autopull && over_thresh;
  assign out_go     = do_out && !out_stall;

  assign bus.fifo_ready = !rst && (pull_fifo || refill_bg);
  assign bus.stall      = !rst && (pull_stall || out_stall);

  // Shift datapath; shifting by DATA_W yields zero, so N = DATA_W needs no special case.
  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] osr_shifted;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_sat;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shift_out   = '0;
    osr_shifted = '0;
    if (bus.cfg_shiftdir) begin
      shift_out   = osr & ~({DATA_W{1'b1}} << n_eff);
      osr_shifted = osr >> n_eff;
    end else begin
      shift_out   = osr >> (FULL_CNT - n_eff);
      osr_shifted = osr << n_eff;
    end
    cnt_sum = {1'b0, cnt} + {1'b0, n_eff};
    cnt_sat = (cnt_sum > {1'b0, FULL_CNT}) ? FULL_CNT : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      osr         <= '0;
      cnt         <= FULL_CNT;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_go;
      if (bus.mov_en) begin
        osr <= bus.mov_data;
        cnt <= '0;
      end else if (pull_fifo || refill_bg) begin
        osr <= bus.fifo_data;
        cnt <= '0;
      end else if (pull_x) begin
        osr <= bus.x_data;
        cnt <= '0;
      end else if (out_go) begin
        osr        <= osr_shifted;
        cnt        <= cnt_sat;
        out_data_q <= shift_out;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.osr_count = cnt;
endmodule

// File: tb/tb_osr_autopull_engine.sv
// Directed bench for osr_autopull_engine: a bit-serial reference model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_osr_autopull_engine;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osr_autopull_engine_if #(.DATA_W(DW)) bus ();
  osr_autopull_engine #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: current and next.
  bit [31:0] m_osr, m_od, n_osr, n_od;
  int        m_cnt, n_cnt;
  bit        m_ov, n_ov;

  always @(negedge clk) begin
    int  t, n;
    bit  e_ready, e_stall;
    bit [31:0] res;
    if (rst) begin
      m_osr = 0; m_cnt = DW; m_od = 0; m_ov = 0;
      n_osr = 0; n_cnt = DW; n_od = 0; n_ov = 0;
      check("rst_ready", bus.fifo_ready, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_count", bus.osr_count, DW);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data",  bus.out_data, 0);
    end else begin
      t = (bus.cfg_pull_thresh == 0) ? DW : int'(bus.cfg_pull_thresh);
      n = (bus.out_count == 0) ? DW : int'(bus.out_count);
      e_ready = 0; e_stall = 0;
      n_osr = m_osr; n_cnt = m_cnt; n_od = m_od; n_ov = 0;
      if (bus.mov_en) begin
        n_osr = bus.mov_data; n_cnt = 0;
      end else if (bus.pull_req) begin
        if (bus.pull_ifempty && m_cnt < t) begin
        end else if (bus.fifo_valid) begin
          n_osr = bus.fifo_data; n_cnt = 0; e_ready = 1;
        end else if (bus.pull_block) begin
          e_stall = 1;
        end else begin
          n_osr = bus.x_data; n_cnt = 0;
        end
      end else begin
        if (bus.out_en && bus.cfg_autopull && m_cnt >= t) begin
          e_stall = 1;
        end else if (bus.out_en) begin
          res = 0;
          for (int i = 0; i < n; i++) begin
            if (bus.cfg_shiftdir) begin
              res[i] = n_osr[0];
              n_osr  = n_osr >> 1;
            end else begin
              res   = (res << 1) | 32'(n_osr[31]);
              n_osr = n_osr << 1;
            end
          end
          n_od  = res;
          n_ov  = 1;
          n_cnt = (m_cnt + n > DW) ? DW : m_cnt + n;
        end
        if (bus.cfg_autopull && m_cnt >= t && bus.fifo_valid) begin
          n_osr = bus.fifo_data; n_cnt = 0; e_ready = 1;
        end
      end
      check("m_ready", bus.fifo_ready, e_ready);
      check("m_stall", bus.stall, e_stall);
      check("m_count", bus.osr_count, m_cnt);
      check("m_valid", bus.out_valid, m_ov);
      check("m_data",  bus.out_data, m_od);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_osr = 0; m_cnt = DW; m_od = 0; m_ov = 0;
    end else begin
      m_osr = n_osr; m_cnt = n_cnt; m_od = n_od; m_ov = n_ov;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mov_en = 0; bus.pull_req = 0; bus.pull_block = 0; bus.pull_ifempty = 0;
    bus.out_en = 0; bus.fifo_valid = 0;
  endtask

  initial begin
    bus.cfg_shiftdir = 1; bus.cfg_autopull = 0; bus.cfg_pull_thresh = 0;
    bus.mov_data = 0; bus.x_data = 0; bus.out_count = 0; bus.fifo_data = 0;
    idle();
    cyc(); cyc();
    check("reset_count", bus.osr_count, 32);
    check("reset_valid", bus.out_valid, 0);
    check("reset_stall", bus.stall, 0);
    rst = 0;
    cyc();

    // Right shift, two OUT 8.
    bus.mov_en = 1; bus.mov_data = 32'hDEADBEEF;
    cyc();
    bus.mov_en = 0; bus.out_en = 1; bus.out_count = 8;
    cyc();
    check("r_out1", bus.out_data, 32'hEF);
    check("r_cnt1", bus.osr_count, 8);
    check("r_val1", bus.out_valid, 1);
    cyc();
    check("r_out2", bus.out_data, 32'hBE);
    check("r_cnt2", bus.osr_count, 16);
    idle(); cyc();
    check("idle_valid", bus.out_valid, 0);
    check("idle_hold",  bus.out_data, 32'hBE);

    // Left shift, OUT 1 then OUT 32.
    bus.cfg_shiftdir = 0; bus.mov_en = 1; bus.mov_data = 32'h80000001;
    cyc();
    bus.mov_en = 0; bus.out_en = 1; bus.out_count = 1;
    cyc();
    check("l_out1", bus.out_data, 32'h1);
    check("l_cnt1", bus.osr_count, 1);
    bus.out_count = 0;
    cyc();
    check("l_out32", bus.out_data, 32'h2);
    check("l_cnt32", bus.osr_count, 32);
    bus.out_count = 4;
    cyc();
    check("l_empty_out", bus.out_data, 32'h0);
    check("l_empty_cnt", bus.osr_count, 32);
    idle(); cyc();

    // Autopull, threshold 16.
    bus.cfg_shiftdir = 1; bus.cfg_autopull = 1; bus.cfg_pull_thresh = 16;
    bus.mov_en = 1; bus.mov_data = 32'h12345678;
    cyc();
    bus.mov_en = 0; bus.out_en = 1; bus.out_count = 16;
    cyc();
    check("ap_out1", bus.out_data, 32'h5678);
    check("ap_cnt1", bus.osr_count, 16);
    for (int i = 0; i < 3; i++) begin
      #1 check("ap_stall_hold", bus.stall, 1);
      check("ap_no_pop", bus.fifo_ready, 0);
      cyc();
    end
    bus.fifo_valid = 1; bus.fifo_data = 32'hCAFEF00D;
    #1 check("ap_pop", bus.fifo_ready, 1);
    check("ap_stall_refill", bus.stall, 1);
    cyc();
    bus.fifo_valid = 0;
    check("ap_cnt_refill", bus.osr_count, 0);
    #1 check("ap_stall_clear", bus.stall, 0);
    cyc();
    check("ap_out2", bus.out_data, 32'hF00D);
    check("ap_cnt2", bus.osr_count, 16);
    idle(); bus.cfg_autopull = 0; bus.cfg_pull_thresh = 0;
    cyc();

    // Blocking PULL on empty FIFO, then non-blocking PULL from X.
    bus.pull_req = 1; bus.pull_block = 1;
    #1 check("pb_stall", bus.stall, 1);
    cyc(); cyc();
    check("pb_stall2", bus.stall, 1);
    bus.fifo_valid = 1; bus.fifo_data = 32'h11223344;
    #1 check("pb_pop", bus.fifo_ready, 1);
    check("pb_go", bus.stall, 0);
    cyc();
    idle();
    check("pb_cnt", bus.osr_count, 0);
    bus.pull_req = 1; bus.x_data = 32'hA5A5A5A5;
    #1 check("pnb_nopop", bus.fifo_ready, 0);
    check("pnb_nostall", bus.stall, 0);
    cyc();
    idle(); bus.out_en = 1; bus.out_count = 0;
    cyc();
    check("pnb_x", bus.out_data, 32'hA5A5A5A5);
    idle(); cyc();

    // PULL IfEmpty no-op, then MOV over PULL.
    bus.mov_en = 1; bus.mov_data = 32'hFFFF0000;
    cyc();
    idle(); bus.out_en = 1; bus.out_count = 4;
    cyc();
    idle(); bus.pull_req = 1; bus.pull_ifempty = 1; bus.fifo_valid = 1; bus.fifo_data = 32'h99;
    #1 check("ife_nopop", bus.fifo_ready, 0);
    cyc();
    check("ife_cnt", bus.osr_count, 4);
    bus.pull_ifempty = 0; bus.mov_en = 1; bus.mov_data = 32'h0F0F0F0F;
    #1 check("mov_nopop", bus.fifo_ready, 0);
    cyc();
    check("mov_cnt", bus.osr_count, 0);
    idle(); bus.out_en = 1; bus.out_count = 8;
    cyc();
    check("mov_win", bus.out_data, 32'h0F);

    // Reset during a stalled OUT.
    bus.cfg_autopull = 1; bus.out_count = 0;
    cyc();
    #1 check("pre_rst_stall", bus.stall, 1);
    rst = 1;
    #1 check("rst_stall", bus.stall, 0);
    check("rst_cnt", bus.osr_count, 32);
    check("rst_valid", bus.out_valid, 0);
    cyc(); cyc();
    idle(); bus.cfg_autopull = 0; rst = 0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/osr_autopull_engine.md
# osr_autopull_engine

Parametrised output shift register for the PIO state machine datapath: it sits between the TX FIFO and the OUT/PULL/MOV execution unit. It generalises the OSR to a configurable data width and adds features:
- a valid/ready pop handshake to the FIFO
- blocking and non-blocking PULL, with scratch-X fallback
- PULL IfEmpty
- an explicit stall output for the instruction sequencer
- registered OUT data with a valid strobe

## Interface
- DATA_W, 32, OSR/FIFO word width; power of two, 8..32. CW = log2(DATA_W).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_shiftdir  in  1  1 = shift right (LSB first), 0 = shift left (MSB first).
- cfg_autopull  in  1  autopull enable.
- cfg_pull_thresh  in  CW  pull threshold; 0 means DATA_W.
- mov_en  in  1  MOV OSR: load mov_data.
- mov_data  in  DATA_W  MOV source.
- pull_req  in  1  PULL instruction.
- pull_block  in  1  PULL block flag.
- pull_ifempty  in  1  PULL IfEmpty flag.
- x_data  in  DATA_W  scratch X, used by a non-blocking PULL on an empty FIFO.
- out_en  in  1  OUT instruction.
- out_count  in  CW  OUT bit count; 0 means DATA_W.
- fifo_data  in  DATA_W  TX FIFO head word.
- fifo_valid  in  1  TX FIFO not empty.
- fifo_ready  out  1  pop strobe, combinational; only ever asserted with fifo_valid.
- stall  out  1  current instruction did not complete; sequencer re-presents it next cycle. Combinational.
- out_data  out  DATA_W  shifted-out bits, right-justified, upper bits zero. Registered.
- out_valid  out  1  one-cycle strobe, registered; set the cycle after an OUT completes.
- osr_count  out  CW+1  bits consumed; 0 = full, DATA_W = empty. Registered.

## Operation
- State: osr (DATA_W), cnt (CW+1). Reset: osr = 0, cnt = DATA_W, out_data = 0, out_valid = 0. Combinational outputs are 0 during reset.
- Effective values: T = (cfg_pull_thresh == 0) ? DATA_W : cfg_pull_thresh; N = (out_count == 0) ? DATA_W : out_count. The threshold test is done in CW+1 bits.
- Priority when several requests are high: mov_en > pull_req > out_en. Lower-priority requests are ignored that cycle; stall = 0 for them.
- MOV: osr = mov_data, cnt = 0.
- PULL, evaluated in order:
  - pull_ifempty && cnt < T: no-op, completes.
  - else fifo_valid: osr = fifo_data, cnt = 0, fifo_ready = 1.
  - else pull_block: stall = 1, no state change.
  - else: osr = x_data, cnt = 0.
- OUT when cfg_autopull && cnt >= T: stall = 1. If fifo_valid, an autopull refill happens the same cycle (osr = fifo_data, cnt = 0, fifo_ready = 1), so the re-presented OUT completes on the next cycle.
- OUT otherwise: completes.
  - Right shift: out_data = osr[N-1:0]; osr = osr >> N.
  - Left shift: out_data = osr[DATA_W-1 -: N]; osr = osr << N.
  - Vacated bits fill with zero. cnt = min(cnt + N, DATA_W), saturating. out_valid = 1 next cycle.
- OUT with autopull disabled and cnt = DATA_W: completes and shifts out zeros; cnt stays DATA_W.
- Background autopull: in any cycle with no mov_en/pull_req, if cfg_autopull && cnt >= T && fifo_valid, refill as above. An OUT request in that cycle still stalls.
- Idle (no request, no refill): state holds; out_valid = 0; out_data holds its last value.

## Timing
- fifo_ready and stall: same cycle as the request, combinational from inputs and registered state.
- osr, cnt, osr_count, out_data, out_valid update on the rising clk edge following the accepted operation. OUT latency is 1 cycle.
- FIFO pop is complete on the edge where fifo_ready = 1; the FIFO advances its head on that edge.
- Configuration inputs are sampled every cycle; a change takes effect immediately.
- rst asserted mid-operation: state returns to reset values asynchronously; a pending stall is dropped.

## Test plan
- DATA_W = 32, reset then MOV 0xDEADBEEF, right shift, OUT N = 8 twice -> out_data 0xEF then 0xBE; osr_count 8 then 16.
- Left shift, MOV 0x80000001, OUT N = 1 -> out_data 0x1, osr = 0x00000002. Then OUT N = 0 (32) -> out_data 0x00000002, osr_count 32.
- Autopull on, T = 16, MOV 0x12345678, OUT 16 -> count 16. Next OUT with fifo_valid = 0 -> stall held for 3 cycles. Raise fifo_valid with 0xCAFEF00D -> fifo_ready pulse and refill; next OUT 16 gives 0xF00D.
- PULL block with empty FIFO -> stall stays high until fifo_valid. Non-blocking PULL with empty FIFO and x_data = 0xA5A5A5A5 -> osr = 0xA5A5A5A5, no fifo_ready.
- PULL IfEmpty with count 4, T = 32 -> no-op, no pop. mov_en and pull_req both high -> MOV wins, no pop.
- Assert rst during a stalled OUT -> osr_count 32, out_valid 0, stall 0.
